// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states
// and the latency-counter sizing helper.
package md_defs;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // Counter must hold the larger latency as a load value.
    function automatic int cnt_w(input int mult_lat, input int div_lat);
        int m;
        m = (mult_lat > div_lat) ? mult_lat : div_lat;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply and divide producing {hi, lo},
// including the divide-by-zero and signed-overflow results.
module md_arith
    import md_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               is_div, signed_div;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, mag_b_safe;
    logic [WIDTH-1:0]   uq, ur, q, r;
    logic               div_zero, div_ovf, div_norm;

    always_comb begin
        a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
        b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
        a_zx   = {{WIDTH{1'b0}}, a};
        b_zx   = {{WIDTH{1'b0}}, b};
        // Low 2W bits of a sign-extended product equal the signed product.
        prod_s = a_sx * b_sx;
        prod_u = a_zx * b_zx;

        is_div     = (op == MD_DIV) || (op == MD_DIVU);
        signed_div = (op == MD_DIV);
        neg_a      = signed_div & a[WIDTH-1];
        neg_b      = signed_div & b[WIDTH-1];
        mag_a      = neg_a ? (~a + 1'b1) : a;
        mag_b      = neg_b ? (~b + 1'b1) : b;
        mag_b_safe = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
        uq         = mag_a / mag_b_safe;
        ur         = mag_a % mag_b_safe;
        q          = (neg_a ^ neg_b) ? (~uq + 1'b1) : uq;
        r          = neg_a ? (~ur + 1'b1) : ur;

        div_zero = is_div && (b == '0);
        div_ovf  = signed_div && (a == MIN_NEG) && (b == '1);
        div_norm = is_div && !div_zero && !div_ovf;

        hi = '0;
        lo = '0;
        unique case (1'b1)
            op == MD_MULT:  {hi, lo} = prod_s;
            op == MD_MULTU: {hi, lo} = prod_u;
            div_zero: begin
                hi = a;
                lo = '1;
            end
            div_ovf: begin
                hi = '0;
                lo = a;
            end
            div_norm: begin
                hi = r;
                lo = q;
            end
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO: result is computed at accept,
// held pending for the op latency, then committed unless cancelled.
module md_unit
    import md_defs::*;
#(
    parameter int WIDTH     = 32,
    parameter int MULT_LAT  = MULT_LAT_DEF,
    parameter int DIV_LAT   = DIV_LAT_DEF,
    parameter bit ASSERT_ON = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_w(MULT_LAT, DIV_LAT);

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pend_hi, pend_lo;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             is_md, is_div, go;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op (op),
        .a  (a),
        .b  (b),
        .hi (res_hi),
        .lo (res_lo)
    );

    assign is_md  = (op == MD_MULT) || (op == MD_MULTU) ||
                    (op == MD_DIV)  || (op == MD_DIVU);
    assign is_div = (op == MD_DIV)  || (op == MD_DIVU);
    assign go     = start && !cancel;
    assign busy   = (state == S_BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (go && is_md) begin
                        state   <= S_BUSY;
                        cnt     <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                    end else if (go && op == MD_MTHI) begin
                        hi <= a;
                    end else if (go && op == MD_MTLO) begin
                        lo <= a;
                    end
                end
                S_BUSY: begin
                    // Cancel beats a coincident commit.
                    if (cancel) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CW'(1)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        hi    <= pend_hi;
                        lo    <= pend_lo;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        if (ASSERT_ON && !rst) begin
            assert (!(start && busy));
        end
    end

endmodule
